data_mem_controller: RTL and testbench



---
 rtl/data_mem_controller_pkg.sv | 19 +
 rtl/data_mem_controller_channel.sv | 96 +++++++++
 rtl/data_mem_controller.sv | 150 +++++++++++++++
 tb/tb_data_mem_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data-memory controller: data/address words and the
// per-channel transaction state.
package data_mem_controller_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] data_memory_address_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } mem_channel_state_t;

endpackage

// File: rtl/data_mem_controller_channel.sv
// One memory channel: latches a claimed lane request, issues it to memory and
// relays the completion back to the owning lane until it drops valid.
module mem_channel
  import data_mem_controller_pkg::*;
#(
  parameter int LANE_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim_i,
  input  logic                 claim_write_i,
  input  logic [LANE_W-1:0]    claim_lane_i,
  input  data_memory_address_t claim_addr_i,
  input  data_t                claim_data_i,
  input  logic                 owner_read_valid_i,
  input  logic                 owner_write_valid_i,
  output logic                 mem_read_valid_o,
  output data_memory_address_t mem_read_address_o,
  input  logic                 mem_read_ready_i,
  input  data_t                mem_read_data_i,
  output logic                 mem_write_valid_o,
  output data_memory_address_t mem_write_address_o,
  output data_t                mem_write_data_o,
  input  logic                 mem_write_ready_i,
  output logic [LANE_W-1:0]    owner_o,
  output logic                 relay_read_o,
  output logic                 relay_write_o,
  output data_t                relay_data_o,
  output logic                 busy_o
);

  mem_channel_state_t   state_q, state_d;
  logic [LANE_W-1:0]    owner_q;
  data_memory_address_t addr_q;
  data_t                wdata_q;
  data_t                rdata_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Payload registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && claim_i) begin
      owner_q <= claim_lane_i;
      addr_q  <= claim_addr_i;
      wdata_q <= claim_data_i;
    end
    if (state_q == READ_WAITING && mem_read_ready_i) rdata_q <= mem_read_data_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (claim_i) state_d = claim_write_i ? WRITE_WAITING : READ_WAITING;
      READ_WAITING:   if (mem_read_ready_i) state_d = READ_RELAYING;
      WRITE_WAITING:  if (mem_write_ready_i) state_d = WRITE_RELAYING;
      READ_RELAYING:  if (!owner_read_valid_i) state_d = IDLE;
      WRITE_RELAYING: if (!owner_write_valid_i) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid_o    = 1'b0;
    mem_read_address_o  = '0;
    mem_write_valid_o   = 1'b0;
    mem_write_address_o = '0;
    mem_write_data_o    = '0;
    relay_read_o        = 1'b0;
    relay_write_o       = 1'b0;
    relay_data_o        = '0;
    case (state_q)
      READ_WAITING: begin
        mem_read_valid_o   = 1'b1;
        mem_read_address_o = addr_q;
      end
      WRITE_WAITING: begin
        mem_write_valid_o   = 1'b1;
        mem_write_address_o = addr_q;
        mem_write_data_o    = wdata_q;
      end
      READ_RELAYING: begin
        relay_read_o = 1'b1;
        relay_data_o = rdata_q;
      end
      WRITE_RELAYING: relay_write_o = 1'b1;
      default: ;
    endcase
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: rtl/data_mem_controller.sv
// Multiplexes NUM_CONSUMERS lane load/store requests onto NUM_CHANNELS memory
// channels with round-robin claiming, one outstanding transaction per channel.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 32,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CONSUMERS-1:0]  consumer_read_valid,
  input  data_memory_address_t      consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]  consumer_read_ready,
  output data_t                     consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]  consumer_write_valid,
  input  data_memory_address_t      consumer_write_address [NUM_CONSUMERS],
  input  data_t                     consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]  consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]   mem_read_valid,
  output data_memory_address_t      mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]   mem_read_ready,
  input  data_t                     mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]   mem_write_valid,
  output data_memory_address_t      mem_write_address [NUM_CHANNELS],
  output data_t                     mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]   mem_write_ready,
  output logic                      busy
);

  localparam int LANE_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [LANE_W-1:0]        rr_q, rr_d;
  logic [NUM_CHANNELS-1:0]  claim, claim_write, ch_busy, relay_read, relay_write;
  logic [NUM_CHANNELS-1:0]  owner_rv, owner_wv;
  logic [LANE_W-1:0]        claim_lane [NUM_CHANNELS];
  logic [LANE_W-1:0]        ch_owner [NUM_CHANNELS];
  data_memory_address_t     claim_addr [NUM_CHANNELS];
  data_t                    claim_data [NUM_CHANNELS];
  data_t                    relay_data [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  int                       lane;
  logic [LANE_W-1:0]        lane_sel;

  // Wrap is an explicit compare so non-power-of-two lane counts stay in range.
  function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] l);
    if (int'(l) >= NUM_CONSUMERS - 1) return '0;
    return l + LANE_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Idle channels claim in ascending index; each excludes lanes already owned
  // or claimed by a lower channel on this edge.
  always_comb begin
    taken    = '0;
    found    = 1'b0;
    lane     = 0;
    lane_sel = '0;
    rr_d     = rr_q;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_busy[c]) taken[ch_owner[c]] = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      claim[c]       = 1'b0;
      claim_write[c] = 1'b0;
      claim_lane[c]  = '0;
      claim_addr[c]  = '0;
      claim_data[c]  = '0;
      found          = 1'b0;
      if (!ch_busy[c]) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          lane = int'(rr_q) + k;
          if (lane >= NUM_CONSUMERS) lane = lane - NUM_CONSUMERS;
          lane_sel = LANE_W'(lane);
          if (!found && !taken[lane_sel] &&
              (consumer_read_valid[lane_sel] || consumer_write_valid[lane_sel])) begin
            found          = 1'b1;
            claim[c]       = 1'b1;
            claim_write[c] = !consumer_read_valid[lane_sel];
            claim_lane[c]  = lane_sel;
            claim_addr[c]  = consumer_read_valid[lane_sel] ? consumer_read_address[lane_sel]
                                                           : consumer_write_address[lane_sel];
            claim_data[c]  = consumer_write_data[lane_sel];
          end
        end
        if (found) begin
          taken[claim_lane[c]] = 1'b1;
          rr_d = lane_inc(claim_lane[c]);
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign owner_rv[c] = consumer_read_valid[ch_owner[c]];
    assign owner_wv[c] = consumer_write_valid[ch_owner[c]];

    mem_channel #(.LANE_W(LANE_W)) u_channel (
      .clk                 (clk),
      .reset               (reset),
      .claim_i             (claim[c]),
      .claim_write_i       (claim_write[c]),
      .claim_lane_i        (claim_lane[c]),
      .claim_addr_i        (claim_addr[c]),
      .claim_data_i        (claim_data[c]),
      .owner_read_valid_i  (owner_rv[c]),
      .owner_write_valid_i (owner_wv[c]),
      .mem_read_valid_o    (mem_read_valid[c]),
      .mem_read_address_o  (mem_read_address[c]),
      .mem_read_ready_i    (mem_read_ready[c]),
      .mem_read_data_i     (mem_read_data[c]),
      .mem_write_valid_o   (mem_write_valid[c]),
      .mem_write_address_o (mem_write_address[c]),
      .mem_write_data_o    (mem_write_data[c]),
      .mem_write_ready_i   (mem_write_ready[c]),
      .owner_o             (ch_owner[c]),
      .relay_read_o        (relay_read[c]),
      .relay_write_o       (relay_write[c]),
      .relay_data_o        (relay_data[c]),
      .busy_o              (ch_busy[c])
    );

    // A lane must hold its request until the completion is relayed.
    a_read_held:  assert property (@(posedge clk) disable iff (reset)
                                   mem_read_valid[c] |-> owner_rv[c]);
    a_write_held: assert property (@(posedge clk) disable iff (reset)
                                   mem_write_valid[c] |-> owner_wv[c]);
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      consumer_read_data[i] = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ch_owner[c] == LANE_W'(i) && relay_read[c]) begin
          consumer_read_ready[i] = 1'b1;
          consumer_read_data[i]  = relay_data[c];
        end
        if (ch_owner[c] == LANE_W'(i) && relay_write[c]) consumer_write_ready[i] = 1'b1;
      end
    end
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_data_mem_controller.sv
// Randomised and directed bench for data_mem_controller with a transaction-level
// reference model of the channel pool and a behavioural memory responder.
module tb_data_mem_controller;
  import data_mem_controller_pkg::*;

  localparam int N = 32;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0] rv, wv, rrdy, wrdy;
  data_memory_address_t ra [N];
  data_memory_address_t wa [N];
  data_t wd [N];
  data_t rd [N];
  logic [C-1:0] mrv, mrr, mwv, mwr;
  data_memory_address_t mra [C];
  data_memory_address_t mwa [C];
  data_t mrd [C];
  data_t mwd [C];
  logic busy;

  data_mem_controller #(.NUM_CONSUMERS(N), .NUM_CHANNELS(C)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rrdy), .consumer_read_data(rd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wrdy),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr),
    .busy(busy)
  );

  // Reference model: each channel is free, waiting on memory, or relaying.
  int    m_phase [C];
  int    m_owner [C];
  bit    m_wr [C];
  data_memory_address_t m_addr [C];
  data_t m_wd [C];
  data_t m_rd [C];
  int    m_rr;
  int    claims_total, claim31_at;

  data_t mem [256];
  bit    mem_auto;
  int    lat_min, lat_max, max_conc;
  int    wcnt [C];

  bit    rand_mode;
  bit [N-1:0] sticky;
  bit [N-1:0] rseen, wseen;
  int    served [N];
  int    wserved [N];
  data_t got [N];
  int    rd_cyc [N];
  int    wr_cyc [N];
  int    cyc;

  int checks, failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit busy_pre [C];
    bit [N-1:0] tk;
    int rr_pre, l;
    if (reset) begin
      for (int c = 0; c < C; c++) m_phase[c] = 0;
      m_rr = 0;
      return;
    end
    tk = '0;
    rr_pre = m_rr;
    for (int c = 0; c < C; c++) begin
      busy_pre[c] = (m_phase[c] != 0);
      if (busy_pre[c]) tk[m_owner[c]] = 1'b1;
    end
    for (int c = 0; c < C; c++) begin
      if (m_phase[c] == 1) begin
        if (m_wr[c] ? mwr[c] : mrr[c]) begin
          m_phase[c] = 2;
          if (!m_wr[c]) m_rd[c] = mrd[c];
        end
      end else if (m_phase[c] == 2) begin
        if (!(m_wr[c] ? wv[m_owner[c]] : rv[m_owner[c]])) m_phase[c] = 0;
      end
    end
    for (int c = 0; c < C; c++) begin
      if (!busy_pre[c]) begin
        for (int k = 0; k < N; k++) begin
          l = (rr_pre + k) % N;
          if ((rv[l] || wv[l]) && !tk[l]) begin
            m_phase[c] = 1;
            m_owner[c] = l;
            m_wr[c]    = !rv[l];
            m_addr[c]  = rv[l] ? ra[l] : wa[l];
            m_wd[c]    = wd[l];
            tk[l]      = 1'b1;
            m_rr       = (l + 1) % N;
            claims_total++;
            if (l == N - 1 && claim31_at < 0) claim31_at = claims_total;
            break;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [C-1:0] e_mrv, e_mwv;
    logic [N-1:0] e_rrdy, e_wrdy;
    data_t e_rd [N];
    e_mrv = '0; e_mwv = '0; e_rrdy = '0; e_wrdy = '0;
    for (int i = 0; i < N; i++) e_rd[i] = '0;
    for (int c = 0; c < C; c++) begin
      if (m_phase[c] == 1 && !m_wr[c]) e_mrv[c] = 1'b1;
      if (m_phase[c] == 1 &&  m_wr[c]) e_mwv[c] = 1'b1;
      if (m_phase[c] == 2 && !m_wr[c]) begin
        e_rrdy[m_owner[c]] = 1'b1;
        e_rd[m_owner[c]]   = m_rd[c];
      end
      if (m_phase[c] == 2 && m_wr[c]) e_wrdy[m_owner[c]] = 1'b1;
    end
    chk("mem_read_valid", mrv, e_mrv);
    chk("mem_write_valid", mwv, e_mwv);
    chk("consumer_read_ready", rrdy, e_rrdy);
    chk("consumer_write_ready", wrdy, e_wrdy);
    chk("busy", busy, (e_mrv | e_mwv) != 0 || (e_rrdy | e_wrdy) != 0);
    for (int c = 0; c < C; c++) begin
      if (e_mrv[c]) chk("mem_read_address", mra[c], m_addr[c]);
      if (e_mwv[c]) begin
        chk("mem_write_address", mwa[c], m_addr[c]);
        chk("mem_write_data", mwd[c], m_wd[c]);
      end
    end
    for (int i = 0; i < N; i++) chk("consumer_read_data", rd[i], e_rd[i]);
  endtask

  task automatic respond();
    int conc;
    conc = 0;
    for (int c = 0; c < C; c++) begin
      mrr[c] = 1'b0;
      mwr[c] = 1'b0;
      mrd[c] = data_t'($urandom);
      if (mrv[c] || mwv[c]) begin
        conc++;
        if (mem_auto) begin
          if (wcnt[c] <= 0) begin
            if (mrv[c]) begin
              mrr[c] = 1'b1;
              mrd[c] = mem[mra[c]];
            end else begin
              mwr[c] = 1'b1;
              mem[mwa[c]] = mwd[c];
            end
          end else wcnt[c]--;
        end
      end else wcnt[c] = lat_min + int'($urandom_range(lat_max - lat_min));
    end
    if (conc > max_conc) max_conc = conc;
  endtask

  task automatic lanes();
    bit was_idle;
    int r;
    for (int i = 0; i < N; i++) begin
      was_idle = !rv[i] && !wv[i];
      if (rv[i] && rrdy[i]) begin
        if (!rseen[i]) begin
          got[i] = rd[i]; served[i]++; rd_cyc[i] = cyc; rseen[i] = 1'b1;
        end
        if (!rand_mode || $urandom_range(1) == 0) begin rv[i] = 1'b0; rseen[i] = 1'b0; end
      end
      if (wv[i] && wrdy[i]) begin
        if (!wseen[i]) begin wserved[i]++; wr_cyc[i] = cyc; wseen[i] = 1'b1; end
        if (!rand_mode || $urandom_range(1) == 0) begin wv[i] = 1'b0; wseen[i] = 1'b0; end
      end
      if (was_idle && sticky[i]) begin
        rv[i] = 1'b1; ra[i] = data_memory_address_t'(i);
      end else if (was_idle && rand_mode && $urandom_range(7) == 0) begin
        r = int'($urandom_range(3));
        ra[i] = data_memory_address_t'($urandom);
        wa[i] = data_memory_address_t'($urandom);
        wd[i] = data_t'($urandom);
        if (r != 2) rv[i] = 1'b1;
        if (r >= 2) wv[i] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
    respond();
    lanes();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((rv != 0 || wv != 0 || busy) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_done", {rv, wv, busy}, '0);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo; lat_max = hi;
    for (int c = 0; c < C; c++) wcnt[c] = lo;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b1; rv = '0; wv = '0; mrr = '0; mwr = '0;
    sticky = '0; rseen = '0; wseen = '0; rand_mode = 1'b0; mem_auto = 1'b1;
    claims_total = 0; claim31_at = -1; m_rr = 0; max_conc = 0;
    for (int c = 0; c < C; c++) begin m_phase[c] = 0; m_owner[c] = 0; m_wr[c] = 0; mrd[c] = '0; end
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; wa[i] = '0; wd[i] = '0; served[i] = 0; wserved[i] = 0;
      got[i] = '0; rd_cyc[i] = 0; wr_cyc[i] = 0;
    end
    for (int a = 0; a < 256; a++) mem[a] = data_t'(a) ^ 8'h5A;
    set_lat(0, 0);
    cycle(); cycle();
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_read_valid", mrv, '0);
    chk("reset_consumer_read_ready", rrdy, '0);
    reset = 1'b0;

    // Single read: lane 5 reads 0x10 which holds 0xAB.
    mem[8'h10] = 8'hAB;
    rv[5] = 1'b1; ra[5] = 8'h10;
    cycle();
    chk("single_issue", mrv, 4'b0001);
    chk("single_addr", mra[0], 8'h10);
    cycle();
    chk("single_ready", rrdy[5], 1'b1);
    chk("single_data", rd[5], 8'hAB);
    chk("single_mem_valid_low", mrv, 4'b0000);
    cycle();
    chk("single_idle", busy, 1'b0);

    // Mixed: even lanes write i to address i, then odd lanes read i-1.
    set_lat(0, 2);
    for (int i = 0; i < N; i += 2) begin
      wv[i] = 1'b1; wa[i] = data_memory_address_t'(i); wd[i] = data_t'(i);
    end
    drain(400);
    for (int i = 1; i < N; i += 2) begin
      rv[i] = 1'b1; ra[i] = data_memory_address_t'(i - 1);
    end
    drain(400);
    for (int i = 1; i < N; i += 2) chk("mixed_read", got[i], data_t'(i - 1));

    // Full contention: every lane reads at once with fixed latency.
    set_lat(1, 1);
    max_conc = 0;
    for (int i = 0; i < N; i++) begin
      served[i] = 0; rv[i] = 1'b1; ra[i] = data_memory_address_t'(i + 8'h40);
    end
    drain(600);
    chk("full_max_concurrent", max_conc, 4);
    for (int i = 0; i < N; i++) begin
      chk("full_data", got[i], data_t'(i + 8'h40) ^ 8'h5A);
      chk("full_served_once", served[i], 1);
    end

    // Both valids on lane 3: read first, then the write.
    set_lat(0, 0);
    rv[3] = 1'b1; ra[3] = 8'h20;
    wv[3] = 1'b1; wa[3] = 8'h21; wd[3] = 8'h77;
    cycle();
    chk("both_read_first", {mrv, mwv}, 8'b0001_0000);
    drain(100);
    chk("both_read_data", got[3], 8'h20 ^ 8'h5A);
    chk("both_write_mem", mem[8'h21], 8'h77);
    chk("both_order", rd_cyc[3] < wr_cyc[3], 1'b1);

    // Fairness: lanes 0..7 re-request continuously, lane 31 asks once.
    set_lat(0, 1);
    served[31] = 0; claim31_at = -1;
    begin
      int start;
      start = claims_total;
      sticky = 32'h0000_00FF;
      rv[31] = 1'b1; ra[31] = 8'h33;
      repeat (60) cycle();
      sticky = '0;
      drain(200);
      chk("fair_claimed_in_time", claim31_at >= 0 && (claim31_at - start) <= N, 1'b1);
      chk("fair_served", served[31], 1);
    end

    // Reset while four channels are waiting on a stalled memory.
    mem_auto = 1'b0;
    set_lat(0, 0);
    for (int i = 0; i < 4; i++) begin rv[i] = 1'b1; ra[i] = data_memory_address_t'(8'h80 + i); end
    cycle(); cycle();
    chk("rstmid_pre_valid", mrv, 4'hF);
    reset = 1'b1; rv = '0; wv = '0;
    cycle();
    chk("rstmid_mem_read_valid", mrv, '0);
    chk("rstmid_mem_write_valid", mwv, '0);
    chk("rstmid_read_ready", rrdy, '0);
    chk("rstmid_busy", busy, 1'b0);
    reset = 1'b0; mem_auto = 1'b1;
    rv[2] = 1'b1; ra[2] = 8'h90;
    rv[30] = 1'b1; ra[30] = 8'h91;
    cycle();
    chk("rstmid_ch0_lane2", mra[0], 8'h90);
    chk("rstmid_ch1_lane30", mra[1], 8'h91);
    drain(100);

    // Random traffic.
    set_lat(0, 3);
    rand_mode = 1'b1;
    repeat (1500) cycle();
    rand_mode = 1'b0;
    drain(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
